timer_sched: RTL

//  Multi-channel one-shot/periodic timer scheduler on a single shared prescaled tick counter.
//  NCH software channels each hold a compare deadline. A round-robin scanner checks one channel
//  per clk, so the block needs one wrap-safe comparator, not NCH of them.

---
 rtl/timer_sched_pkg.sv | 34 +++
 rtl/timer_sched_pri.sv | 25 ++
 rtl/timer_sched.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_sched_pkg.sv
// -----------------------------------------------------------------------------
// timer_sched_pkg
//   Shared definitions for the timer scheduler: register byte offsets, the
//   CON register layout and the wrap-safe deadline comparison.
// -----------------------------------------------------------------------------
package timer_sched_pkg;

    // Register byte offsets
    localparam int CON_OFF  = 'h00;
    localparam int CNT_OFF  = 'h04;
    localparam int PEND_OFF = 'h08;
    localparam int IE_OFF   = 'h0C;
    localparam int ARM_OFF  = 'h10;
    localparam int CMP_BASE = 'h20;    // CMP_n at CMP_BASE + 4*n
    localparam int PRD_BASE = 'h40;    // PRD_n at PRD_BASE + 4*n

    localparam int ID_W = 3;           // width of sched_id (up to 8 channels)

    typedef struct packed {
        logic [7:0] psc;
        logic       gie;
        logic       en;
    } con_t;

    // A deadline is due once (cnt - cmp) is non-negative as a signed value.
    // This stays correct across the 2^32 wrap provided deadlines are kept
    // less than 2^31 ticks ahead of the counter.
    function automatic logic is_due(input logic [31:0] cnt, input logic [31:0] cmp);
        logic [31:0] diff;
        diff = cnt - cmp;
        return ~diff[31];
    endfunction

endpackage

// File: rtl/timer_sched_pri.sv
// -----------------------------------------------------------------------------
// timer_sched_pri
//   Combinational lowest-index priority encoder.
//   Ports:
//     req  in   NCH  request vector (pend & ie)
//     id   out  3    index of the lowest set bit of req; 0 when req is empty
// -----------------------------------------------------------------------------
module timer_sched_pri
    import timer_sched_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]  req,
    output logic [ID_W-1:0] id
);

    // Walk from the top down so the lowest set index is the last one written.
    always_comb begin
        id = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) id = ID_W'(i);
        end
    end

endmodule

// File: rtl/timer_sched.sv
// -----------------------------------------------------------------------------
// timer_sched
//   Multi-channel one-shot/periodic timer scheduler built on one shared,
//   prescaled tick counter. A round-robin scanner tests one channel per clk
//   against its deadline, so a single wrap-safe comparator serves all
//   channels. Expired channels set pending bits that drive one interrupt.
//
//   Optional feature: define TIMER_SCHED_PERIODIC_EN to add PRD_n registers
//   and auto-reload; without it PRD_n reads 0, ignores writes, and every
//   channel is one-shot.
//
//   Ports:
//     clk        in   1    system clock
//     rst        in   1    asynchronous active-high reset
//     icb_wr     in   1    register write strobe
//     icb_wadr   in   AW   write byte address
//     icb_wdat   in   32   write data
//     icb_wack   out  1    write ack (same cycle as icb_wr)
//     icb_rd     in   1    register read strobe
//     icb_radr   in   AW   read byte address
//     icb_rdat   out  32   read data, combinational; 0 when idle or unmapped
//     icb_rack   out  1    read ack (same cycle as icb_rd)
//     sched_int  out  1    level interrupt = gie & |(pend & ie)
//     sched_id   out  3    lowest channel with pend & ie set; 0 when none
// -----------------------------------------------------------------------------
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int AW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          icb_wr,
    input  logic [AW-1:0] icb_wadr,
    input  logic [31:0]   icb_wdat,
    output logic          icb_wack,
    input  logic          icb_rd,
    input  logic [AW-1:0] icb_radr,
    output logic [31:0]   icb_rdat,
    output logic          icb_rack,
    output logic          sched_int,
    output logic [2:0]    sched_id
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    con_t           con_q,  con_d;
    logic [7:0]     div_q,  div_d;
    logic [31:0]    cnt_q,  cnt_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] ie_q,   ie_d;
    logic [NCH-1:0] arm_q,  arm_d;
    logic [31:0]    cmp_q [NCH];
    logic [31:0]    cmp_d [NCH];
    logic [IW-1:0]  idx_q,  idx_d;
`ifdef TIMER_SCHED_PERIODIC_EN
    logic [31:0]    prd_q [NCH];
    logic [31:0]    prd_d [NCH];
    logic [NCH-1:0] wr_prd;
`endif

    logic           wr_con, wr_cnt, wr_pend, wr_ie;
    logic [NCH-1:0] wr_cmp;
    logic           hit;

    assign icb_wack = icb_wr;
    assign icb_rack = icb_rd;

    // One-hot write strobes
    always_comb begin
        wr_con  = icb_wr && (icb_wadr == AW'(CON_OFF));
        wr_cnt  = icb_wr && (icb_wadr == AW'(CNT_OFF));
        wr_pend = icb_wr && (icb_wadr == AW'(PEND_OFF));
        wr_ie   = icb_wr && (icb_wadr == AW'(IE_OFF));
        for (int n = 0; n < NCH; n++) begin
            wr_cmp[n] = icb_wr && (icb_wadr == AW'(CMP_BASE + 4 * n));
`ifdef TIMER_SCHED_PERIODIC_EN
            wr_prd[n] = icb_wr && (icb_wadr == AW'(PRD_BASE + 4 * n));
`endif
        end
    end

    // Scanner compares against the registered counter, so a CNT write in the
    // same cycle is seen only from the next cycle on.
    assign hit = con_q.en && arm_q[idx_q] && is_due(cnt_q, cmp_q[idx_q]);

    // NOTE: every _d signal gets its default (hold) value first, so no path
    // through this block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        con_d = con_q;
        if (wr_con) begin
            con_d.psc = icb_wdat[15:8];
            con_d.gie = icb_wdat[1];
            con_d.en  = icb_wdat[0];
        end

        // Prescaler and tick counter; a CNT write overrides the increment.
        div_d = div_q;
        cnt_d = cnt_q;
        if (!con_q.en) begin
            div_d = '0;
        end else if (div_q == con_q.psc) begin
            div_d = '0;
            cnt_d = cnt_q + 32'd1;
        end else begin
            div_d = div_q + 8'd1;
        end
        if (wr_cnt) begin
            cnt_d = icb_wdat;
            div_d = '0;
        end

        idx_d = idx_q;
        if (con_q.en) idx_d = (idx_q == IW'(NCH - 1)) ? '0 : idx_q + 1'b1;

        ie_d = wr_ie ? icb_wdat[NCH-1:0] : ie_q;

        // W1C first, so a same-cycle hit below re-sets the bit (set wins).
        pend_d = pend_q;
        if (wr_pend) pend_d = pend_q & ~icb_wdat[NCH-1:0];

        arm_d = arm_q;
        for (int n = 0; n < NCH; n++) begin
            cmp_d[n] = cmp_q[n];
`ifdef TIMER_SCHED_PERIODIC_EN
            prd_d[n] = wr_prd[n] ? icb_wdat : prd_q[n];
`endif
        end

        // A CMP write to the scanned channel suppresses its hit entirely.
        if (hit && !wr_cmp[idx_q]) begin
            pend_d[idx_q] = 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
            if (prd_q[idx_q] != 32'd0) cmp_d[idx_q] = cmp_q[idx_q] + prd_q[idx_q];
            else                       arm_d[idx_q] = 1'b0;
`else
            arm_d[idx_q] = 1'b0;
`endif
        end

        for (int n = 0; n < NCH; n++) begin
            if (wr_cmp[n]) begin
                cmp_d[n] = icb_wdat;
                arm_d[n] = 1'b1;
            end
        end
    end

    // Read mux; idle or unmapped reads return 0.
    always_comb begin
        icb_rdat = '0;
        if (icb_rd) begin
            if (icb_radr == AW'(CON_OFF))  icb_rdat = {16'd0, con_q.psc, 6'd0, con_q.gie, con_q.en};
            if (icb_radr == AW'(CNT_OFF))  icb_rdat = cnt_q;
            if (icb_radr == AW'(PEND_OFF)) icb_rdat = 32'(pend_q);
            if (icb_radr == AW'(IE_OFF))   icb_rdat = 32'(ie_q);
            if (icb_radr == AW'(ARM_OFF))  icb_rdat = 32'(arm_q);
            for (int n = 0; n < NCH; n++) begin
                if (icb_radr == AW'(CMP_BASE + 4 * n)) icb_rdat = cmp_q[n];
`ifdef TIMER_SCHED_PERIODIC_EN
                if (icb_radr == AW'(PRD_BASE + 4 * n)) icb_rdat = prd_q[n];
`endif
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            con_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            pend_q <= '0;
            ie_q   <= '0;
            arm_q  <= '0;
            idx_q  <= '0;
            // NOTE: the per-channel arrays are small register files, not RAM,
            // so they are reset with everything else to give defined readback.
            for (int n = 0; n < NCH; n++) begin
                cmp_q[n] <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
                prd_q[n] <= '0;
`endif
            end
        end else begin
            con_q  <= con_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ie_q   <= ie_d;
            arm_q  <= arm_d;
            idx_q  <= idx_d;
            for (int n = 0; n < NCH; n++) begin
                cmp_q[n] <= cmp_d[n];
`ifdef TIMER_SCHED_PERIODIC_EN
                prd_q[n] <= prd_d[n];
`endif
            end
        end
    end

    assign sched_int = con_q.gie & |(pend_q & ie_q);

    timer_sched_pri #(.NCH(NCH)) u_pri (
        .req (pend_q & ie_q),
        .id  (sched_id)
    );

endmodule
